// File: rtl/refill_burst_controller.sv
// Refill burst controller: one burst request per miss, forwards BURST_LEN words with offsets.
// Optional stall-timeout abort is compiled in when REFILL_TIMEOUT_EN is defined.
module refill_burst_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int OFFSET_BITS    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              i_req_valid,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] i_req_block_addr,
    input  logic [OFFSET_BITS-1:0]            i_req_offset,
    output logic                              o_req_ready,
    output logic [ADDR_WIDTH-1:0]             o_mem_req_addr,
    output logic                              o_mem_req_valid,
    input  logic                              i_mem_req_ready,
    input  logic [DATA_WIDTH-1:0]             i_mem_data,
    input  logic                              i_mem_data_valid,
    output logic                              o_mem_data_ready,
    output logic [DATA_WIDTH-1:0]             o_word_data,
    output logic [OFFSET_BITS-1:0]            o_word_offset,
    output logic                              o_word_valid,
    output logic                              o_word_is_missed,
    input  logic                              i_word_halt,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error
);
    localparam int BLOCK_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int CNT_W   = OFFSET_BITS + 1;
    localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(2 ** OFFSET_BITS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2 ** OFFSET_BITS - 1);

`ifdef REFILL_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, RECV, DONE, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;
`endif

    state_t                 state;
    state_t                 state_next;
    logic [BLOCK_W-1:0]     block_addr;
    logic [OFFSET_BITS-1:0] req_offset;
    logic [CNT_W-1:0]       beat_cnt;
    logic [CNT_W-1:0]       word_cnt;
    logic [DATA_WIDTH-1:0]  word_data;
    logic [OFFSET_BITS-1:0] word_offset;
    logic                   word_valid;
    logic                   beat_accept;
    logic                   word_xfer;

`ifdef REFILL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;
    logic               progress;
    logic               timeout;

    // Any handshake counts as progress; the abort fires on the cycle the count would reach the limit.
    assign progress = ((state == REQ) & i_mem_req_ready) | beat_accept | word_xfer;
    assign timeout  = ((state == REQ) | (state == RECV)) & ~progress &
                      (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
        end else if (((state == REQ) | (state == RECV)) & ~progress) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end else begin
            stall_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        o_req_ready      = 1'b0;
        o_mem_req_valid  = 1'b0;
        o_mem_data_ready = 1'b0;
        o_done           = 1'b0;
        o_error          = 1'b0;
        beat_accept      = 1'b0;
        word_xfer        = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_next = REQ;
            end
            REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) state_next = RECV;
`ifdef REFILL_TIMEOUT_EN
                else if (timeout) state_next = ERROR;
`endif
            end
            RECV: begin
                // The output register can take a new beat whenever it is empty or draining this cycle.
                o_mem_data_ready = (~word_valid | ~i_word_halt) & (beat_cnt < BURST_LEN);
                beat_accept      = o_mem_data_ready & i_mem_data_valid;
                word_xfer        = word_valid & ~i_word_halt;
                if (word_xfer && (word_cnt == LAST_WORD)) state_next = DONE;
`ifdef REFILL_TIMEOUT_EN
                else if (timeout) state_next = ERROR;
`endif
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
`ifdef REFILL_TIMEOUT_EN
            ERROR: begin
                o_error    = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            block_addr  <= '0;
            req_offset  <= '0;
            beat_cnt    <= '0;
            word_cnt    <= '0;
            word_data   <= '0;
            word_offset <= '0;
            word_valid  <= 1'b0;
        end else begin
            if ((state == IDLE) && i_req_valid) begin
                block_addr <= i_req_block_addr;
                req_offset <= i_req_offset;
                beat_cnt   <= '0;
                word_cnt   <= '0;
            end
            if (beat_accept) begin
                word_data   <= i_mem_data;
                word_offset <= beat_cnt[OFFSET_BITS-1:0];
                word_valid  <= 1'b1;
                beat_cnt    <= beat_cnt + CNT_W'(1);
            end else if (word_xfer) begin
                word_valid <= 1'b0;
            end
            if (word_xfer) word_cnt <= word_cnt + CNT_W'(1);
`ifdef REFILL_TIMEOUT_EN
            if (timeout) word_valid <= 1'b0;
`endif
        end
    end

    assign o_mem_req_addr   = {block_addr, {OFFSET_BITS{1'b0}}};
    assign o_word_data      = word_data;
    assign o_word_offset    = word_offset;
    assign o_word_valid     = word_valid;
    assign o_word_is_missed = word_valid & (word_offset == req_offset);
    assign o_busy           = (state != IDLE);

endmodule

// File: tb/tb_refill_burst_controller.sv
// Randomized bench for refill_burst_controller with a transaction-level memory/consumer model.
module tb_refill_burst_controller;
    localparam int ADDR_WIDTH  = 16;
    localparam int OFFSET_BITS = 4;
    localparam int DATA_WIDTH  = 32;
    localparam int BURST_LEN   = 2 ** OFFSET_BITS;
    localparam int BLOCK_W     = ADDR_WIDTH - OFFSET_BITS;

    logic                   clk = 1'b0;
    logic                   arst_n;
    logic                   i_req_valid;
    logic [BLOCK_W-1:0]     i_req_block_addr;
    logic [OFFSET_BITS-1:0] i_req_offset;
    logic                   o_req_ready;
    logic [ADDR_WIDTH-1:0]  o_mem_req_addr;
    logic                   o_mem_req_valid;
    logic                   i_mem_req_ready;
    logic [DATA_WIDTH-1:0]  i_mem_data;
    logic                   i_mem_data_valid;
    logic                   o_mem_data_ready;
    logic [DATA_WIDTH-1:0]  o_word_data;
    logic [OFFSET_BITS-1:0] o_word_offset;
    logic                   o_word_valid;
    logic                   o_word_is_missed;
    logic                   i_word_halt;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_error;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    refill_burst_controller #(
        .ADDR_WIDTH(ADDR_WIDTH), .OFFSET_BITS(OFFSET_BITS),
        .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .i_req_valid(i_req_valid), .i_req_block_addr(i_req_block_addr), .i_req_offset(i_req_offset),
        .o_req_ready(o_req_ready), .o_mem_req_addr(o_mem_req_addr), .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready), .i_mem_data(i_mem_data), .i_mem_data_valid(i_mem_data_valid),
        .o_mem_data_ready(o_mem_data_ready), .o_word_data(o_word_data), .o_word_offset(o_word_offset),
        .o_word_valid(o_word_valid), .o_word_is_missed(o_word_is_missed), .i_word_halt(i_word_halt),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        i_req_valid      = 1'b0;
        i_req_block_addr = '0;
        i_req_offset     = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_data       = '0;
        i_mem_data_valid = 1'b0;
        i_word_halt      = 1'b0;
    endtask

    // One refill: memory sends n_beats in order after the request handshake; the model expects
    // exactly the first BURST_LEN of them, in order, with done one cycle after the last transfer.
    task automatic applyStimulus(
        input logic [BLOCK_W-1:0]     blk,
        input logic [OFFSET_BITS-1:0] off,
        input int                     req_delay,
        input int                     gap_pct,
        input int                     halt_pct,
        input int                     halt_word,
        input int                     n_beats,
        input logic [DATA_WIDTH-1:0]  base_data,
        input int                     reset_at_beat,
        input int                     exp_done_cyc
    );
        logic [DATA_WIDTH-1:0]  beats[$];
        logic [DATA_WIDTH-1:0]  held_data;
        logic [OFFSET_BITS-1:0] held_off;
        logic [ADDR_WIDTH-1:0]  exp_addr;
        int beat_idx  = 0;
        int beats_acc = 0;
        int words_out = 0;
        int last_xfer = -1;
        int done_cnt  = 0;
        int halt_left = 3;
        logic req_acc   = 1'b0;
        logic finished  = 1'b0;
        logic was_reset = 1'b0;
        logic hold      = 1'b0;

        held_data = '0;
        held_off  = '0;
        exp_addr  = ADDR_WIDTH'(int'(blk) * BURST_LEN);
        for (int i = 0; i < n_beats; i++)
            beats.push_back((base_data != 0) ? base_data + DATA_WIDTH'(i) : DATA_WIDTH'($urandom()));

        i_req_valid      = 1'b1;
        i_req_block_addr = blk;
        i_req_offset     = off;
        @(negedge clk);
        checkOutput("req_ready", 64'(o_req_ready), 64'(1));
        @(posedge clk); #1;
        i_req_valid = 1'b0;

        for (int cyc = 1; cyc < 400; cyc++) begin
            i_mem_req_ready  = !req_acc && (cyc > req_delay);
            i_mem_data_valid = 1'b0;
            if (req_acc && beat_idx < n_beats) begin
                i_mem_data       = beats[beat_idx];
                i_mem_data_valid = ($urandom_range(99) >= gap_pct);
            end
            i_word_halt = 1'b0;
            if (halt_word >= 0) begin
                if (o_word_valid && int'(o_word_offset) == halt_word && halt_left > 0) begin
                    i_word_halt = 1'b1;
                    halt_left--;
                end
            end else begin
                i_word_halt = ($urandom_range(99) < halt_pct);
            end

            @(negedge clk);
            if (last_xfer >= 0 && cyc == last_xfer + 2) begin
                checkOutput("idle_req_ready", 64'(o_req_ready), 64'(1));
                checkOutput("idle_busy", 64'(o_busy), 64'(0));
                checkOutput("idle_done", 64'(o_done), 64'(0));
                checkOutput("idle_word_valid", 64'(o_word_valid), 64'(0));
                checkOutput("no_error", 64'(o_error), 64'(0));
                finished = 1'b1;
                break;
            end
            checkOutput("busy", 64'(o_busy), 64'(1));
            checkOutput("req_ready_busy", 64'(o_req_ready), 64'(0));
            checkOutput("done_pulse", 64'(o_done), 64'(last_xfer >= 0 && cyc == last_xfer + 1));
            if (o_done) done_cnt++;

            if (!req_acc) begin
                checkOutput("mem_req_valid", 64'(o_mem_req_valid), 64'(1));
                checkOutput("mem_req_addr", 64'(o_mem_req_addr), 64'(exp_addr));
                if (i_mem_req_ready) req_acc = 1'b1;
            end else begin
                checkOutput("mem_req_dropped", 64'(o_mem_req_valid), 64'(0));
            end

            if (hold) begin
                checkOutput("held_valid", 64'(o_word_valid), 64'(1));
                checkOutput("held_data", 64'(o_word_data), 64'(held_data));
                checkOutput("held_offset", 64'(o_word_offset), 64'(held_off));
            end
            hold = 1'b0;
            if (o_word_valid && i_word_halt) begin
                checkOutput("halt_blocks_beat", 64'(o_mem_data_ready), 64'(0));
                hold      = 1'b1;
                held_data = o_word_data;
                held_off  = o_word_offset;
            end else if (o_word_valid) begin
                if (words_out >= BURST_LEN) begin
                    checkOutput("extra_word", 64'(1), 64'(0));
                end else begin
                    checkOutput("word_data", 64'(o_word_data), 64'(beats[words_out]));
                    checkOutput("word_offset", 64'(o_word_offset), 64'(words_out));
                    checkOutput("word_missed", 64'(o_word_is_missed), 64'(words_out == int'(off)));
                    words_out++;
                    if (words_out == BURST_LEN) last_xfer = cyc;
                end
            end else begin
                checkOutput("missed_no_word", 64'(o_word_is_missed), 64'(0));
            end

            if (beats_acc >= BURST_LEN) checkOutput("no_extra_beat", 64'(o_mem_data_ready), 64'(0));
            if (i_mem_data_valid && o_mem_data_ready) begin
                beats_acc++;
                beat_idx++;
            end

            if (reset_at_beat >= 0 && beats_acc == reset_at_beat) begin
                arst_n = 1'b0;
                #1;
                checkOutput("rst_req_ready", 64'(o_req_ready), 64'(1));
                checkOutput("rst_word_valid", 64'(o_word_valid), 64'(0));
                checkOutput("rst_busy", 64'(o_busy), 64'(0));
                checkOutput("rst_mem_req_valid", 64'(o_mem_req_valid), 64'(0));
                clearInputs();
                @(posedge clk); #1;
                arst_n = 1'b1;
                @(negedge clk);
                checkOutput("rst_no_done", 64'(o_done), 64'(0));
                checkOutput("rst_idle", 64'(o_req_ready), 64'(1));
                was_reset = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end

        clearInputs();
        if (!was_reset) begin
            checkOutput("finished", 64'(finished), 64'(1));
            checkOutput("done_count", 64'(done_cnt), 64'(1));
            checkOutput("beats_accepted", 64'(beats_acc), 64'(BURST_LEN));
            if (exp_done_cyc >= 0) checkOutput("done_cycle", 64'(last_xfer + 1), 64'(exp_done_cyc));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        arst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 64'(o_req_ready), 64'(1));
        checkOutput("reset_busy", 64'(o_busy), 64'(0));
        checkOutput("reset_mem_req_valid", 64'(o_mem_req_valid), 64'(0));
        checkOutput("reset_mem_req_addr", 64'(o_mem_req_addr), 64'(0));
        checkOutput("reset_mem_data_ready", 64'(o_mem_data_ready), 64'(0));
        checkOutput("reset_word_valid", 64'(o_word_valid), 64'(0));
        checkOutput("reset_word_data", 64'(o_word_data), 64'(0));
        checkOutput("reset_word_offset", 64'(o_word_offset), 64'(0));
        checkOutput("reset_word_missed", 64'(o_word_is_missed), 64'(0));
        checkOutput("reset_done", 64'(o_done), 64'(0));
        checkOutput("reset_error", 64'(o_error), 64'(0));
        @(posedge clk); #1;
        arst_n = 1'b1;

        applyStimulus(12'hABC, 4'd5, 0, 0, 0, -1, 16, 32'h100, -1, 19);
        applyStimulus(12'h123, 4'd0, 4, 0, 0, -1, 16, 32'h200, -1, 23);
        applyStimulus(12'h0F0, 4'd7, 0, 0, 0, 7, 16, 32'h300, -1, 22);
        applyStimulus(12'hFFF, 4'd15, 0, 0, 0, -1, 17, 32'h400, -1, 19);
        applyStimulus(12'h555, 4'd2, 1, 0, 0, -1, 16, 32'h500, 8, -1);
        applyStimulus(12'h556, 4'd9, 0, 0, 0, -1, 16, 32'h600, -1, 19);
        for (int r = 0; r < 6; r++) begin
            applyStimulus(BLOCK_W'($urandom()), OFFSET_BITS'($urandom()), $urandom_range(3),
                          30, 30, -1, 16 + $urandom_range(1), '0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
